gpio_port_responder: RTL and testbench



---
 rtl/gpio_port_responder.sv | 110 +++++++++++
 tb/tb_gpio_port_responder.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/gpio_port_responder.sv
// Memory-mapped 8-bit GPIO responder: OUT/DIR/PIN/FLAG/MASK/POL registers,
// synchronized pin inputs, sticky edge flags and a maskable level interrupt.
// Ports: clk, reset (sync, active-high), CS/WE/OE/address bus strobes,
//        data (CPU bus, driven only on reads), gpio (pins), irq (level).
module gpio_port_responder #(
    parameter int DATA_WIDTH  = 8,
    parameter int SYNC_STAGES = 2,
    parameter int ARM_CYCLES  = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  CS,
    input  logic                  WE,
    input  logic                  OE,
    input  logic [2:0]            address,
    inout  wire  [DATA_WIDTH-1:0] data,
    inout  wire  [DATA_WIDTH-1:0] gpio,
    output logic                  irq
);

    localparam int CW = $clog2(ARM_CYCLES + 2);
    localparam logic [CW-1:0] ARM_MAX = CW'(ARM_CYCLES + 1);
    localparam logic [CW-1:0] ARM_THR = CW'(ARM_CYCLES);

    logic [DATA_WIDTH-1:0] out_r;
    logic [DATA_WIDTH-1:0] dir_r;
    logic [DATA_WIDTH-1:0] flag_r;
    logic [DATA_WIDTH-1:0] mask_r;
    logic [DATA_WIDTH-1:0] pol_r;
    logic [DATA_WIDTH-1:0] sync_q [SYNC_STAGES];
    logic [DATA_WIDTH-1:0] prev_q;
    logic [CW-1:0]         arm_cnt;

    logic                  wr_en;
    logic                  rd_en;
    logic                  armed;
    logic [DATA_WIDTH-1:0] sync;
    logic [DATA_WIDTH-1:0] ev;
    logic [DATA_WIDTH-1:0] clr;
    logic [DATA_WIDTH-1:0] rd_data;

    assign wr_en = CS & WE;
    assign rd_en = CS & OE & ~WE;
    assign armed = (arm_cnt > ARM_THR);
    assign sync  = sync_q[SYNC_STAGES-1];

    // Per-bit polarity: POL=1 detects falling, POL=0 detects rising.
    assign ev  = (pol_r & ~sync & prev_q) | (~pol_r & sync & ~prev_q);
    assign clr = (wr_en && address == 3'd3) ? data : '0;

    assign irq = |(flag_r & mask_r);

    always_comb begin
        rd_data = '0;
        case (address)
            3'd0:    rd_data = out_r;
            3'd1:    rd_data = dir_r;
            3'd2:    rd_data = sync;
            3'd3:    rd_data = flag_r;
            3'd4:    rd_data = mask_r;
            3'd5:    rd_data = pol_r;
            default: rd_data = '0;
        endcase
    end

    assign data = rd_en ? rd_data : {DATA_WIDTH{1'bz}};

    for (genvar i = 0; i < DATA_WIDTH; i++) begin : g_pin
        assign gpio[i] = dir_r[i] ? out_r[i] : 1'bz;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_r   <= '0;
            dir_r   <= '0;
            flag_r  <= '0;
            mask_r  <= '0;
            pol_r   <= '0;
            prev_q  <= '0;
            arm_cnt <= '0;
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= '0;
            end
        end else begin
            sync_q[0] <= gpio;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
            prev_q <= sync;

            if (arm_cnt != ARM_MAX) begin
                arm_cnt <= arm_cnt + 1'b1;
            end

            // A new edge wins over a same-cycle clear.
            flag_r <= (flag_r & ~clr) | (armed ? ev : '0);

            if (wr_en) begin
                case (address)
                    3'd0:    out_r  <= data;
                    3'd1:    dir_r  <= data;
                    3'd4:    mask_r <= data;
                    3'd5:    pol_r  <= data;
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_gpio_port_responder.sv
// Self-checking bench for gpio_port_responder: directed vectors, a
// sample-history reference model and a per-cycle compare process.
module tb_gpio_port_responder;

    logic       clk = 1'b0;
    logic       reset;
    logic       CS, WE, OE;
    logic [2:0] addr;
    logic [7:0] tb_data;
    logic       tb_data_en;
    logic [7:0] ext_val;
    logic [7:0] ext_en;
    wire  [7:0] data_w;
    wire  [7:0] gpio_w;
    logic       irq;

    int n_chk  = 0;
    int n_pass = 0;

    assign data_w = tb_data_en ? tb_data : 8'hzz;
    for (genvar i = 0; i < 8; i++) begin : g_ext
        assign gpio_w[i] = ext_en[i] ? ext_val[i] : 1'bz;
    end

    gpio_port_responder dut (
        .clk     (clk),
        .reset   (reset),
        .CS      (CS),
        .WE      (WE),
        .OE      (OE),
        .address (addr),
        .data    (data_w),
        .gpio    (gpio_w),
        .irq     (irq)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [7:0] act,
                       input logic [7:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %02h expected %02h", nm, act, exp);
    endtask

    // Reference model: pad samples at each edge kept in a short history;
    // sync is the sample from two edges back, prev from three back.
    logic [7:0] m_out, m_dir, m_flag, m_mask, m_pol;
    logic [7:0] h [3];
    int         done;
    bit         mvalid = 0;
    logic [7:0] pad, sy, pv, ev, clr;

    always @(posedge clk) begin
        if (reset) begin
            m_out = 0; m_dir = 0; m_flag = 0; m_mask = 0; m_pol = 0;
            h[0] = 0; h[1] = 0; h[2] = 0;
            done = 0;
            mvalid = 1;
        end else if (mvalid) begin
            pad = (m_dir & m_out) | (~m_dir & ext_val);
            sy = h[1];
            pv = h[2];
            for (int i = 0; i < 8; i++)
                ev[i] = m_pol[i] ? (!sy[i] && pv[i]) : (sy[i] && !pv[i]);
            if (done < 3) ev = 0;
            clr = (CS && WE && addr == 3'd3) ? data_w : 8'h00;
            m_flag = (m_flag & ~clr) | ev;
            if (CS && WE) begin
                case (addr)
                    3'd0: m_out  = data_w;
                    3'd1: m_dir  = data_w;
                    3'd4: m_mask = data_w;
                    3'd5: m_pol  = data_w;
                    default: ;
                endcase
            end
            h[2] = h[1]; h[1] = h[0]; h[0] = pad;
            if (done < 3) done++;
        end
    end

    function automatic logic [7:0] m_read(input logic [2:0] a);
        case (a)
            3'd0: return m_out;
            3'd1: return m_dir;
            3'd2: return h[1];
            3'd3: return m_flag;
            3'd4: return m_mask;
            3'd5: return m_pol;
            default: return 8'h00;
        endcase
    endfunction

    always @(negedge clk) begin
        if (mvalid) begin
            chk("irq", {7'b0, irq}, {7'b0, |(m_flag & m_mask)});
            chk("gpio_drv", gpio_w & m_dir, m_out & m_dir);
            chk("gpio_in", gpio_w & ~m_dir, ext_val & ~m_dir);
            if (CS && OE && !WE) chk("rd_model", data_w, m_read(addr));
            if (tb_data_en) chk("bus_tb", data_w, tb_data);
        end
    end

    task automatic idle_bus;
        CS = 0; WE = 0; OE = 0; tb_data_en = 0; addr = 0;
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [2:0] a, input logic [7:0] d);
        CS = 1; WE = 1; OE = 0; addr = a; tb_data = d; tb_data_en = 1;
        step(1);
        idle_bus();
    endtask

    task automatic rd(input logic [2:0] a, input logic [7:0] exp,
                      input string nm);
        CS = 1; WE = 0; OE = 1; addr = a;
        @(negedge clk);
        chk(nm, data_w, exp);
        step(1);
        idle_bus();
    endtask

    initial begin
        #200000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

    initial begin
        idle_bus();
        tb_data = 0;
        reset = 1;
        ext_val = 8'hFF;
        ext_en = 8'hFF;
        step(3);
        reset = 0;
        step(5);

        for (int a = 0; a < 8; a++)
            rd(3'(a), (a == 2) ? 8'hFF : 8'h00, "reset_rd");
        chk("reset_irq", {7'b0, irq}, 8'h00);

        wr(3'd1, 8'h0F);
        ext_en = 8'hF0;
        ext_val = 8'h30;
        wr(3'd0, 8'hA5);
        rd(3'd0, 8'hA5, "out_rd");
        step(3);
        rd(3'd2, 8'h35, "pin_mixed");
        rd(3'd3, 8'h05, "flag_rise_drv");
        wr(3'd3, 8'hFF);
        rd(3'd3, 8'h00, "flag_w1c_all");

        wr(3'd1, 8'h00);
        ext_en = 8'hFF;
        ext_val = 8'h00;
        step(4);
        wr(3'd3, 8'hFF);
        wr(3'd4, 8'h01);
        wr(3'd5, 8'h00);
        ext_val = 8'h01;
        step(2);
        chk("irq_k1", {7'b0, irq}, 8'h00);
        step(1);
        chk("irq_k2", {7'b0, irq}, 8'h01);
        rd(3'd3, 8'h01, "flag_rise");

        wr(3'd5, 8'h02);
        ext_val = 8'h03;
        step(4);
        rd(3'd3, 8'h01, "flag_no_rise_pol1");
        ext_val = 8'h01;
        step(4);
        rd(3'd3, 8'h03, "flag_fall");

        wr(3'd3, 8'h01);
        rd(3'd3, 8'h02, "flag_clr0");
        chk("irq_cleared", {7'b0, irq}, 8'h00);
        ext_val = 8'h00;
        step(4);
        ext_val = 8'h01;
        step(2);
        wr(3'd3, 8'h01);
        rd(3'd3, 8'h03, "set_beats_clr");

        CS = 0; WE = 1; addr = 3'd0; tb_data = 8'hFF; tb_data_en = 1;
        step(1);
        idle_bus();
        rd(3'd0, 8'hA5, "cs_low_ignored");

        CS = 1; WE = 1; OE = 1; addr = 3'd4; tb_data = 8'h81;
        tb_data_en = 1;
        @(negedge clk);
        chk("oe_we_bus", data_w, 8'h81);
        step(1);
        idle_bus();
        rd(3'd4, 8'h81, "oe_we_written");

        wr(3'd1, 8'hFF);
        ext_en = 8'h00;
        ext_val = 8'h00;
        step(4);
        rd(3'd3, 8'hA7, "flag_pre_reset");
        reset = 1;
        step(1);
        reset = 0;
        ext_en = 8'hFF;
        chk("rst_irq", {7'b0, irq}, 8'h00);
        for (int a = 0; a < 8; a++)
            rd(3'(a), 8'h00, "rst_rd");
        step(2);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
